set_assoc_icache: RTL and testbench
===================================

# set_assoc_icache

Parametrised set-associative instruction cache placed between the IF stage instruction bus and the external instruction memory bus. It generalises the direct-mapped single-word cache to multi-word lines, 1/2/4 ways and round-robin replacement. It also adds a flush input for fence.i that invalidates the whole cache. It is read-only toward the core and refills lines with sequential single-word Avalon reads.

## Interface
Parameters:
- LINE_SIZE, 16: line size in bytes; power of 2, minimum 4.
- SETS, 32: number of sets; power of 2, minimum 2.
- WAYS, 2: associativity; 1, 2 or 4.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- flush  in  1  single-cycle pulse; invalidate all lines.
- core_avn_req  in  avalon_req_t  from IF. Fields used: read, write, address[31:0].
- core_avn_resp  out  avalon_resp_t  to IF. Fields driven: readdata[31:0], waitrequest.
- mem_avn_req  out  avalon_req_t  to instruction memory. Fields driven: read, write=0, address, writedata=0, byte_enable=4'hF.
- mem_avn_resp  in  avalon_resp_t  from instruction memory. Fields used: readdata, waitrequest.

## Operation
- Address split:
  - OFFSET_W=log2(LINE_SIZE), INDEX_W=log2(SETS), TAG_W=32-OFFSET_W-INDEX_W.
  - index = address[OFFSET_W+INDEX_W-1:OFFSET_W].
  - word = address[OFFSET_W-1:2].
  - WORDS = LINE_SIZE/4.
- Storage:
  - valid bits and tags are held in flops.
  - Data array is per-way synchronous-read RAM of SETS*WORDS x 32.
  - One round-robin victim pointer of log2(WAYS) bits per set.
- FSM states: IDLE, REFILL, FILL_DONE.
- IDLE:
  - Combinational tag compare across all ways of the indexed set.
  - On read with a hit: waitrequest=0, data RAM read issued. Hit in multiple ways cannot occur.
  - On read with a miss: waitrequest=1. Latch the line base address and victim way = ptr[index]. Go to REFILL.
  - On core write: ignored, waitrequest=0, no state change.
- REFILL:
  - mem read=1, address = line_base + 4*req_cnt.
  - req_cnt increments on each cycle where mem waitrequest=0.
  - read drops once req_cnt==WORDS.
  - Each mem readdata arrives the cycle after its acceptance. It is written into the victim way at word resp_cnt, then resp_cnt increments.
  - When resp_cnt reaches WORDS, go to FILL_DONE.
- FILL_DONE (1 cycle):
  - Set the victim tag and valid, unless a flush is pending.
  - Increment ptr[index] modulo WAYS.
  - Return to IDLE. core waitrequest stays 1 in this state.
  - The held core request then re-looks up in IDLE and hits.
- Flush:
  - In IDLE: all valid bits clear at the next edge. A read in the same cycle as flush is treated as a miss.
  - During REFILL or FILL_DONE: set flush_pending. The refill completes, but the filled line is not marked valid. All valid bits clear on the FILL_DONE edge, and flush_pending clears.
- The core must hold address and read stable while waitrequest=1; the block does not re-latch.
- WAYS=1 degenerates to direct-mapped; the ptr logic is a constant 0.

## Timing
- Hit latency: request accepted at cycle T (waitrequest=0); readdata valid at T+1. Back-to-back hits give one word per cycle.
- Miss with zero-wait memory: miss at T; REFILL T+1..T+WORDS+1; FILL_DONE T+WORDS+2; accepted T+WORDS+3; data at T+WORDS+4.
- Each memory waitrequest cycle extends REFILL by one cycle.
- core waitrequest is combinational from state and hit, and is 1 in every non-IDLE state.
- Reset values:
  - State IDLE; all valid=0; ptr=0; req_cnt=resp_cnt=0; flush_pending=0.
  - mem read=0, mem address=0.
  - core readdata register=0.
  - core waitrequest follows the lookup rule, so a read right after reset is a miss.
- Reset mid-refill: abandon immediately to IDLE, leave the partial line invalid, and discard a memory readdata arriving the cycle after reset.

## Test plan
- Cold miss, then hit (LINE_SIZE=16, WAYS=2, zero-wait memory holding word[a]=a):
  - read 0x100 -> mem reads 0x100, 0x104, 0x108, 0x10C; core readdata 0x100 at T+8.
  - Then read 0x108 -> readdata 0x108 one cycle after acceptance, with no mem read.
- Memory stall: mem waitrequest=1 for 3 cycles on the first word -> address 0x100 held; miss latency grows by exactly 3; data correct.
- Conflict eviction (SETS=32, LINE_SIZE=16): lines 0x000, 0x200, 0x400 map to set 0.
  - After filling 0x000 and 0x200, reading 0x400 evicts way 0 (0x000).
  - Re-reading 0x200 hits; re-reading 0x000 misses.
- Flush:
  - After 0x100 is cached, a flush pulse makes the next read of 0x100 miss and refill.
  - A flush during REFILL leaves the refilled line invalid, so one extra refill occurs.
- Reset during REFILL at word 2: mem read drops the next cycle; after reset, a read of the same line performs a full 4-word refill.
- Core write to 0x100: waitrequest=0, no mem traffic, and cached contents are unchanged.

Source files
------------

// File: rtl/set_assoc_icache.sv
// Set-associative read-only instruction cache between the IF-stage Avalon bus and
// instruction memory; multi-word lines refilled by sequential single-word reads.
package avalon_pkg;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;
endpackage

module set_assoc_icache
  import avalon_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int SETS      = 32,
  parameter int WAYS      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  avalon_req_t  core_avn_req,
  output avalon_resp_t core_avn_resp,
  output avalon_req_t  mem_avn_req,
  input  avalon_resp_t mem_avn_resp
);

  localparam int OFFSET_W = $clog2(LINE_SIZE);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;
  localparam int WORDS    = LINE_SIZE / 4;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W    = $clog2(WORDS + 1);
  localparam int RAM_D    = SETS * WORDS;
  localparam int RAM_AW   = $clog2(RAM_D);

  typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

  state_t             state_r;
  logic [INDEX_W-1:0] index_s;
  logic [INDEX_W-1:0] fill_index_s;
  logic [TAG_W-1:0]   tag_s;
  logic [TAG_W-1:0]   fill_tag_s;
  logic [RAM_AW-1:0]  raddr_s;
  logic [RAM_AW-1:0]  waddr_s;
  logic [WAYS-1:0]    way_hit_s;
  logic [WAY_W-1:0]   hit_way_s;
  logic               hit_s;
  logic               lookup_hit_s;
  logic               we_s;
  logic [WAY_W-1:0]   victim_r;
  logic [CNT_W-1:0]   req_cnt_r;
  logic [CNT_W-1:0]   resp_cnt_r;
  logic               resp_pend_r;
  logic               flush_pending_r;
  logic               mem_read_r;
  logic [31:0]        mem_addr_r;
  logic [31:0]        line_base_r;
  logic [31:0]        readdata_r;
  logic [SETS-1:0]    valid_r [WAYS];
  logic [TAG_W-1:0]   tag_r [WAYS][SETS];
  logic [WAY_W-1:0]   ptr_r [SETS];
  logic [31:0]        data_mem [WAYS][RAM_D];
  logic               unused_s;

  // Index and word are contiguous address bits, so the RAM address is one slice.
  assign index_s      = INDEX_W'(core_avn_req.address >> OFFSET_W);
  assign tag_s        = TAG_W'(core_avn_req.address >> (OFFSET_W + INDEX_W));
  assign raddr_s      = RAM_AW'(core_avn_req.address >> 2);
  assign fill_index_s = INDEX_W'(line_base_r >> OFFSET_W);
  assign fill_tag_s   = TAG_W'(line_base_r >> (OFFSET_W + INDEX_W));
  assign waddr_s      = RAM_AW'((line_base_r >> 2) + 32'(resp_cnt_r));
  assign we_s         = (state_r == REFILL) && resp_pend_r && !rst;
  assign unused_s     = ^{core_avn_req.write, core_avn_req.writedata,
                          core_avn_req.byte_enable, core_avn_req.address[1:0],
                          line_base_r[1:0]};

  // Tag compare across all ways of the indexed set; a same-cycle flush forces a miss.
  always_comb begin
    way_hit_s = {WAYS{1'b0}};
    hit_way_s = {WAY_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      way_hit_s[w] = valid_r[w][index_s] && (tag_r[w][index_s] == tag_s);
      hit_way_s    = hit_way_s | (way_hit_s[w] ? WAY_W'(w) : {WAY_W{1'b0}});
    end
    hit_s        = |way_hit_s;
    lookup_hit_s = hit_s && !flush;
  end

  // Core and memory bus responses.
  always_comb begin
    core_avn_resp.readdata    = readdata_r;
    core_avn_resp.waitrequest = (state_r != IDLE) || (core_avn_req.read && !lookup_hit_s);
    mem_avn_req.read          = mem_read_r;
    mem_avn_req.write         = 1'b0;
    mem_avn_req.address       = mem_addr_r;
    mem_avn_req.writedata     = 32'h0000_0000;
    mem_avn_req.byte_enable   = 4'hF;
  end

  // Refill controller, valid/tag arrays and round-robin pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      req_cnt_r       <= {CNT_W{1'b0}};
      resp_cnt_r      <= {CNT_W{1'b0}};
      resp_pend_r     <= 1'b0;
      flush_pending_r <= 1'b0;
      mem_read_r      <= 1'b0;
      mem_addr_r      <= 32'h0000_0000;
      line_base_r     <= 32'h0000_0000;
      victim_r        <= {WAY_W{1'b0}};
      for (int w = 0; w < WAYS; w++) valid_r[w] <= {SETS{1'b0}};
      for (int s = 0; s < SETS; s++) ptr_r[s] <= {WAY_W{1'b0}};
    end else begin
      resp_pend_r <= mem_read_r && !mem_avn_resp.waitrequest;
      case (state_r)
        IDLE: begin
          if (flush) begin
            for (int w = 0; w < WAYS; w++) valid_r[w] <= {SETS{1'b0}};
          end
          if (core_avn_req.read && !lookup_hit_s) begin
            line_base_r <= {core_avn_req.address[31:OFFSET_W], {OFFSET_W{1'b0}}};
            mem_addr_r  <= {core_avn_req.address[31:OFFSET_W], {OFFSET_W{1'b0}}};
            mem_read_r  <= 1'b1;
            req_cnt_r   <= {CNT_W{1'b0}};
            resp_cnt_r  <= {CNT_W{1'b0}};
            victim_r    <= ptr_r[index_s];
            state_r     <= REFILL;
          end
        end
        REFILL: begin
          if (flush) flush_pending_r <= 1'b1;
          if (mem_read_r && !mem_avn_resp.waitrequest) begin
            req_cnt_r  <= req_cnt_r + CNT_W'(1);
            mem_addr_r <= mem_addr_r + 32'd4;
            if (req_cnt_r == CNT_W'(WORDS - 1)) mem_read_r <= 1'b0;
          end
          if (resp_pend_r) begin
            resp_cnt_r <= resp_cnt_r + CNT_W'(1);
            if (resp_cnt_r == CNT_W'(WORDS - 1)) state_r <= FILL_DONE;
          end
        end
        FILL_DONE: begin
          if (flush_pending_r || flush) begin
            for (int w = 0; w < WAYS; w++) valid_r[w] <= {SETS{1'b0}};
          end else begin
            valid_r[victim_r][fill_index_s] <= 1'b1;
            tag_r[victim_r][fill_index_s]   <= fill_tag_s;
          end
          flush_pending_r     <= 1'b0;
          ptr_r[fill_index_s] <= (WAYS > 1) ? WAY_W'(ptr_r[fill_index_s] + 1'b1)
                                            : {WAY_W{1'b0}};
          state_r             <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Refill data lands in the victim way one word per returned beat.
  always_ff @(posedge clk) begin
    if (we_s) data_mem[victim_r][waddr_s] <= mem_avn_resp.readdata;
  end

  // Synchronous hit read into the core readdata register.
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata_r <= 32'h0000_0000;
    end else if ((state_r == IDLE) && core_avn_req.read && lookup_hit_s) begin
      readdata_r <= data_mem[hit_way_s][raddr_s];
    end
  end

endmodule

// File: tb/tb_set_assoc_icache.sv
// Directed bench for set_assoc_icache: a scoreboard of expected readdata and
// memory addresses, popped by monitors as the DUT presents them.
module tb_set_assoc_icache;
  import avalon_pkg::*;

  logic         clk;
  logic         rst;
  logic         flush;
  avalon_req_t  core_req;
  avalon_resp_t core_resp;
  avalon_req_t  mem_req;
  avalon_resp_t mem_resp;

  logic [31:0] mem_rdata = 32'h0;
  int          mem_rd_cnt = 0;
  int          stalls_done = 0;
  int          stall_target = 0;
  logic        mem_wait;

  int checks = 0;
  int errors = 0;
  logic [31:0] q_data[$];
  logic [31:0] q_maddr[$];

  set_assoc_icache #(.LINE_SIZE(16), .SETS(32), .WAYS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .core_avn_req (core_req),
    .core_avn_resp(core_resp),
    .mem_avn_req  (mem_req),
    .mem_avn_resp (mem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: word at address a holds a; data returns the cycle after acceptance.
  assign mem_wait             = mem_req.read && (stalls_done < stall_target);
  assign mem_resp.waitrequest = mem_wait;
  assign mem_resp.readdata    = mem_rdata;

  always @(posedge clk) begin
    if (mem_req.read && !mem_wait) begin
      mem_rdata  <= mem_req.address;
      mem_rd_cnt <= mem_rd_cnt + 1;
    end
    if (mem_wait) stalls_done <= stalls_done + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: core data one cycle after acceptance, memory addresses on acceptance.
  initial begin
    logic acc_pend;
    acc_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (acc_pend) begin
        if (q_data.size() == 0) check("unexpected core data", core_resp.readdata, 32'hFFFF_FFFF);
        else check("core readdata", core_resp.readdata, q_data.pop_front());
      end
      acc_pend = core_req.read && !core_resp.waitrequest && !rst;
      if (mem_req.read && !mem_wait) begin
        if (q_maddr.size() == 0) check("unexpected mem read", mem_req.address, 32'hFFFF_FFFF);
        else check("mem address", mem_req.address, q_maddr.pop_front());
      end else if (mem_req.read && q_maddr.size() != 0) begin
        check("mem address held", mem_req.address, q_maddr[0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Issue one core read and check acceptance latency and memory traffic.
  task automatic core_read(input logic [31:0] addr, input int exp_lat, input int exp_mem,
                           input int refills, input string name);
    int lat;
    int m0;
    m0 = mem_rd_cnt;
    for (int r = 0; r < refills; r++)
      for (int w = 0; w < 4; w++) q_maddr.push_back((addr & 32'hFFFF_FFF0) + 32'(4 * w));
    q_data.push_back(addr);
    core_req.read    = 1'b1;
    core_req.address = addr;
    lat = 0;
    @(negedge clk);
    while (core_resp.waitrequest === 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    @(posedge clk); #1;
    core_req.read = 1'b0;
    check($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
    check($sformatf("%s mem reads", name), 32'(mem_rd_cnt - m0), 32'(exp_mem));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int m0;
    rst      = 1'b1;
    flush    = 1'b0;
    core_req = '0;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("reset mem read", {31'd0, mem_req.read}, 32'd0);
    check("reset mem address", mem_req.address, 32'h0);
    check("reset core readdata", core_resp.readdata, 32'h0);
    check("reset idle waitrequest", {31'd0, core_resp.waitrequest}, 32'd0);
    tick(1);

    // Cold miss, hit in the same line, back-to-back hits
    core_read(32'h100, 7, 4, 1, "cold miss 0x100");
    core_read(32'h108, 0, 0, 0, "hit 0x108");
    core_read(32'h104, 0, 0, 0, "b2b hit 0x104");
    core_read(32'h10C, 0, 0, 0, "b2b hit 0x10C");

    // Core write is ignored
    m0 = mem_rd_cnt;
    core_req.write     = 1'b1;
    core_req.address   = 32'h100;
    core_req.writedata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("write waitrequest", {31'd0, core_resp.waitrequest}, 32'd0);
    tick(1);
    core_req.write = 1'b0;
    tick(3);
    check("write mem reads", 32'(mem_rd_cnt - m0), 32'd0);
    core_read(32'h100, 0, 0, 0, "hit after write");

    // Memory stall of 3 cycles on the first word
    stall_target = stalls_done + 3;
    core_read(32'h180, 10, 4, 1, "stalled miss 0x180");
    core_read(32'h184, 0, 0, 0, "hit 0x184");

    // Conflict eviction in set 0
    core_read(32'h000, 7, 4, 1, "fill 0x000");
    core_read(32'h200, 7, 4, 1, "fill 0x200");
    core_read(32'h400, 7, 4, 1, "evict with 0x400");
    core_read(32'h40C, 0, 0, 0, "hit 0x40C");
    core_read(32'h200, 0, 0, 0, "rehit 0x200");
    core_read(32'h000, 7, 4, 1, "evicted 0x000");

    // Flush while idle
    core_read(32'h104, 0, 0, 0, "hit before flush");
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    core_read(32'h100, 7, 4, 1, "miss after flush");

    // Flush during refill forces a second refill
    fork
      core_read(32'h280, 14, 8, 2, "flush during refill");
      begin
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join
    core_read(32'h28C, 0, 0, 0, "hit after double refill");
    core_read(32'h100, 7, 4, 1, "0x100 flushed");

    // Reset while fetching word 2
    for (int w = 0; w < 3; w++) q_maddr.push_back(32'h500 + 32'(4 * w));
    core_req.read    = 1'b1;
    core_req.address = 32'h500;
    tick(3);
    check("refill word2 address", mem_req.address, 32'h508);
    check("refill word2 read", {31'd0, mem_req.read}, 32'd1);
    rst           = 1'b1;
    core_req.read = 1'b0;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("read drops after reset", {31'd0, mem_req.read}, 32'd0);
    check("idle after reset", {31'd0, core_resp.waitrequest}, 32'd0);
    tick(1);
    core_read(32'h500, 7, 4, 1, "full refill after reset");
    core_read(32'h508, 0, 0, 0, "hit 0x508");

    tick(3);
    check("data queue drained", 32'(q_data.size()), 32'd0);
    check("mem queue drained", 32'(q_maddr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
